interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 152 +++++++++++++++
 tb/tb_interrupt_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Four-source vectored interrupt controller. Rising edges on int_src latch
// sticky pending flags; enabled pending sources are arbitrated (index 0 has
// the highest priority) and offered to the CPU one at a time. There is no
// nesting: once a request is accepted the controller stays in service until
// the CPU signals return.
//
// Ports:
//   clk         in   1   sole clock, rising edge
//   reset       in   1   synchronous, active-high
//   int_src     in   4   raw request lines; a request is a rising edge
//   en_we       in   1   enable-mask write strobe
//   en_wd       in   4   enable-mask write data
//   int_ack     in   1   CPU accepted the offered request
//   int_ret     in   1   CPU returned from the handler
//   irq         out  1   interrupt request to the CPU
//   vector      out  10  handler address of the offered request
//   active_id   out  2   index of the request offered or being serviced
//   in_service  out  1   high while a handler runs
//   pending     out  4   latched pending flags
//   enable      out  4   current enable mask
// -----------------------------------------------------------------------------
module interrupt_controller #(
    parameter logic [9:0] VEC0 = 10'b0000010000,
    parameter logic [9:0] VEC1 = 10'b0000100000,
    parameter logic [9:0] VEC2 = 10'b0000110000,
    parameter logic [9:0] VEC3 = 10'b0001000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] int_src,
    input  logic       en_we,
    input  logic [3:0] en_wd,
    input  logic       int_ack,
    input  logic       int_ret,
    output logic       irq,
    output logic [9:0] vector,
    output logic [1:0] active_id,
    output logic       in_service,
    output logic [3:0] pending,
    output logic [3:0] enable
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [3:0] src_q;
    logic [3:0] rise;
    logic [3:0] eligible;
    logic [3:0] ack_clr;
    logic [1:0] sel_id;
    logic [9:0] sel_vec;
    logic       load;
    logic       ack_fire;

    function automatic logic [9:0] vec_of(input logic [1:0] id);
        logic [9:0] v;
        case (id)
            2'd0:    v = VEC0;
            2'd1:    v = VEC1;
            2'd2:    v = VEC2;
            default: v = VEC3;
        endcase
        return v;
    endfunction

    // Edge detect and eligibility use registered state only, so a new edge
    // becomes pending one edge later and is offered the edge after that.
    always_comb begin
        rise     = int_src & ~src_q;
        eligible = pending & enable;
    end

    // Fixed priority: lowest eligible index wins.
    always_comb begin
        sel_id = 2'd0;
        if (eligible[0])      sel_id = 2'd0;
        else if (eligible[1]) sel_id = 2'd1;
        else if (eligible[2]) sel_id = 2'd2;
        else if (eligible[3]) sel_id = 2'd3;
        sel_vec = vec_of(sel_id);
    end

    // Next-state logic. int_ack only matters in REQ and int_ret only in
    // SERVICE, so a simultaneous pair is resolved by the state alone.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ack_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (eligible != 4'b0000) begin
                    state_nxt = REQ;
                    load      = 1'b1;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_nxt = SERVICE;
                    ack_fire  = 1'b1;
                end
            end
            SERVICE: begin
                if (int_ret) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        ack_clr = 4'b0000;
        if (ack_fire) ack_clr = 4'b0001 << active_id;
    end

    // A fresh edge on the acknowledged source re-sets its flag in the same
    // cycle the ack clears it, so the new request is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            src_q     <= int_src;
            pending   <= 4'b0000;
            enable    <= 4'b0000;
            active_id <= 2'd0;
            vector    <= 10'd0;
        end else begin
            state   <= state_nxt;
            src_q   <= int_src;
            pending <= (pending & ~ack_clr) | rise;
            if (en_we) enable <= en_wd;
            if (load) begin
                active_id <= sel_id;
                vector    <= sel_vec;
            end
        end
    end

    assign irq        = (state == REQ);
    assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

    localparam logic [9:0] VEC0 = 10'b0000010000;
    localparam logic [9:0] VEC1 = 10'b0000100000;
    localparam logic [9:0] VEC2 = 10'b0000110000;
    localparam logic [9:0] VEC3 = 10'b0001000000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] int_src;
    logic       en_we;
    logic [3:0] en_wd;
    logic       int_ack;
    logic       int_ret;
    logic       irq;
    logic [9:0] vector;
    logic [1:0] active_id;
    logic       in_service;
    logic [3:0] pending;
    logic [3:0] enable;

    int checks = 0;
    int errors = 0;

    interrupt_controller dut (
        .clk        (clk),
        .reset      (reset),
        .int_src    (int_src),
        .en_we      (en_we),
        .en_wd      (en_wd),
        .int_ack    (int_ack),
        .int_ret    (int_ret),
        .irq        (irq),
        .vector     (vector),
        .active_id  (active_id),
        .in_service (in_service),
        .pending    (pending),
        .enable     (enable)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are driven and outputs
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_enable(input logic [3:0] m);
        en_we = 1'b1;
        en_wd = m;
        tick();
        en_we = 1'b0;
    endtask

    task automatic ack_then_ret();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
    endtask

    task automatic test_reset();
        int_src = 4'b0000; en_we = 1'b0; en_wd = 4'b0000;
        int_ack = 1'b0; int_ret = 1'b0; reset = 1'b1;
        tick(); tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq actual=%0b required=0", irq); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL rst_insvc actual=%0b required=0", in_service); end
        checks++; if (vector !== 10'd0) begin errors++; $display("FAIL rst_vector actual=%h required=0", vector); end
        checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL rst_id actual=%0d required=0", active_id); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rst_pending actual=%b required=0000", pending); end
        checks++; if (enable !== 4'b0000) begin errors++; $display("FAIL rst_enable actual=%b required=0000", enable); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        write_enable(4'b1111);
        checks++; if (enable !== 4'b1111) begin errors++; $display("FAIL single_enable actual=%b required=1111", enable); end
        int_src = 4'b0100;
        tick();
        int_src = 4'b0000;
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pending actual=%b required=0100", pending); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_early actual=%0b required=0", irq); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq actual=%0b required=1", irq); end
        checks++; if (vector !== VEC2) begin errors++; $display("FAIL single_vector actual=%h required=%h", vector, VEC2); end
        checks++; if (active_id !== 2'd2) begin errors++; $display("FAIL single_id actual=%0d required=2", active_id); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_ack_irq actual=%0b required=0", irq); end
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL single_ack_insvc actual=%0b required=1", in_service); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_ack_pending actual=%b required=0000", pending); end
        checks++; if (vector !== VEC2) begin errors++; $display("FAIL single_svc_vector actual=%h required=%h", vector, VEC2); end
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL single_ret_insvc actual=%0b required=0", in_service); end
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_idle_irq actual=%0b required=0", irq); end
    endtask

    task automatic test_priority();
        int_src = 4'b1010;
        tick();
        int_src = 4'b0000;
        checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL prio_pending actual=%b required=1010", pending); end
        tick();
        checks++; if (active_id !== 2'd1) begin errors++; $display("FAIL prio_first_id actual=%0d required=1", active_id); end
        checks++; if (vector !== VEC1) begin errors++; $display("FAIL prio_first_vec actual=%h required=%h", vector, VEC1); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL prio_ack_pending actual=%b required=1000", pending); end
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL prio_second_irq actual=%0b required=1", irq); end
        checks++; if (active_id !== 2'd3) begin errors++; $display("FAIL prio_second_id actual=%0d required=3", active_id); end
        checks++; if (vector !== VEC3) begin errors++; $display("FAIL prio_second_vec actual=%h required=%h", vector, VEC3); end
        ack_then_ret();
        tick();
    endtask

    task automatic test_mask();
        write_enable(4'b0000);
        int_src = 4'b0001;
        tick();
        int_src = 4'b0000;
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL mask_pending actual=%b required=0001", pending); end
        tick(); tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq_masked actual=%0b required=0", irq); end
        // int_ack while idle must not disturb the pending flag
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL idle_ack_pending actual=%b required=0001", pending); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL idle_ack_insvc actual=%0b required=0", in_service); end
        write_enable(4'b0001);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq_write_edge actual=%0b required=0", irq); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mask_irq_after actual=%0b required=1", irq); end
        checks++; if (vector !== VEC0) begin errors++; $display("FAIL mask_vector actual=%h required=%h", vector, VEC0); end
        // mask change while offered must not withdraw the request
        write_enable(4'b0000);
        tick();
        checks++; if (irq !== 1'b1 || vector !== VEC0) begin errors++; $display("FAIL mask_frozen actual=%0b/%h required=1/%h", irq, vector, VEC0); end
        ack_then_ret();
        tick();
    endtask

    task automatic test_no_nest();
        write_enable(4'b1111);
        int_src = 4'b0010;
        tick();
        int_src = 4'b0000;
        tick();
        checks++; if (active_id !== 2'd1) begin errors++; $display("FAIL nest_id actual=%0d required=1", active_id); end
        // ack and ret together in REQ: only the ack acts
        int_ack = 1'b1; int_ret = 1'b1;
        tick();
        int_ack = 1'b0; int_ret = 1'b0;
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL both_in_req actual=%0b required=1", in_service); end
        int_src = 4'b0001;
        tick();
        int_src = 4'b0000;
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL nest_pending actual=%b required=0001", pending); end
        tick(); tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL nest_irq actual=%0b required=0", irq); end
        checks++; if (active_id !== 2'd1) begin errors++; $display("FAIL nest_id_hold actual=%0d required=1", active_id); end
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        checks++; if (in_service !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL nest_ret actual=%0b/%0b required=0/0", in_service, irq); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL nest_reoffer_irq actual=%0b required=1", irq); end
        checks++; if (vector !== VEC0) begin errors++; $display("FAIL nest_reoffer_vec actual=%h required=%h", vector, VEC0); end
        ack_then_ret();
        tick();
    endtask

    task automatic test_set_wins();
        int_src = 4'b0100;
        tick();
        int_src = 4'b0000;
        tick();
        checks++; if (active_id !== 2'd2 || irq !== 1'b1) begin errors++; $display("FAIL sw_offer actual=%0d/%0b required=2/1", active_id, irq); end
        int_ack = 1'b1; int_src = 4'b0100;
        tick();
        int_ack = 1'b0; int_src = 4'b0000;
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL sw_insvc actual=%0b required=1", in_service); end
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL sw_pending actual=%b required=0100", pending); end
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        tick();
        checks++; if (irq !== 1'b1 || active_id !== 2'd2) begin errors++; $display("FAIL sw_reoffer actual=%0b/%0d required=1/2", irq, active_id); end
        ack_then_ret();
        tick();
    endtask

    task automatic test_reset_mid();
        int_src = 4'b0001;
        tick(); tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rmid_irq_before actual=%0b required=1", irq); end
        reset = 1'b1; en_we = 1'b1; en_wd = 4'b1111;
        tick();
        reset = 1'b0; en_we = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rmid_irq actual=%0b required=0", irq); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rmid_pending actual=%b required=0000", pending); end
        checks++; if (enable !== 4'b0000) begin errors++; $display("FAIL rmid_enable actual=%b required=0000", enable); end
        tick(); tick();
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rmid_release_pending actual=%b required=0000", pending); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rmid_release_irq actual=%0b required=0", irq); end
        int_src = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_no_nest();
        test_set_wins();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
